// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding, width defaults,
// and the configuration-length legality rule used by the controller.
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A pattern must be at least two bits and fit the window.
  function automatic logic len_legal(input logic [3:0] len, input int pat_w);
    return (int'(len) >= 2) && (int'(len) <= pat_w);
  endfunction

endpackage

// File: rtl/seq_match_unit.sv
// Window shift register plus masked comparator; match is combinational on the current bit.
// Latency 0 (caller registers); no backpressure, shifts only when seq_vld is high.
module seq_match_unit
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             seq_bit,
  input  logic             seq_vld,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  // Only PAT_W-1 history bits are kept; the current bit completes the window.
  logic [PAT_W-2:0]  window;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  cand;
  logic [PAT_W-1:0]  mask;

  always_comb begin
    cand = {window, seq_bit};
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match = seq_vld
         && ((int'(fill) + 1) >= int'(len))
         && (((cand ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (seq_vld) begin
      window <= cand[PAT_W-2:0];
      if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: handshake config, run/abort control, match counting.
// Latency: out 1 clk after completing bit; backpressure: cfg_ready low while running.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             seq_bit,
  input  logic             seq_valid,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic [3:0]       len_q, len_nxt;
  logic [CNT_W-1:0] tgt_q, tgt_nxt;
  logic [CNT_W-1:0] cnt_nxt, cnt_inc;
  logic             out_nxt, err_nxt;
  logic             win_clr, hit, run_vld;

  assign busy      = (state == ST_RUN);
  assign cfg_ready = (state != ST_RUN);
  assign done      = (state == ST_DONE);
  assign run_vld   = seq_valid && (state == ST_RUN);
  assign cnt_inc   = match_cnt + CNT_W'(1);

  seq_match_unit #(.PAT_W(PAT_W)) u_match (
    .clk     (clk),
    .resetn  (resetn),
    .seq_bit (seq_bit),
    .seq_vld (run_vld),
    .clear   (win_clr),
    .pattern (pat_q),
    .len     (len_q),
    .match   (hit)
  );

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat_q;
    len_nxt   = len_q;
    tgt_nxt   = tgt_q;
    cnt_nxt   = match_cnt;
    err_nxt   = err;
    out_nxt   = 1'b0;
    win_clr   = 1'b0;
    unique case (state)
      ST_RUN: begin
        // Abort wins over a match completing in the same cycle.
        if (abort) begin
          state_nxt = ST_READY;
        end else if (hit) begin
          out_nxt = 1'b1;
          if (tgt_q == '0) begin
            if (match_cnt != '1) cnt_nxt = cnt_inc;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == tgt_q) state_nxt = ST_DONE;
          end
        end
      end
      default: begin
        if (cfg_valid) begin
          if (len_legal(cfg_len, PAT_W)) begin
            pat_nxt   = cfg_pattern;
            len_nxt   = cfg_len;
            tgt_nxt   = cfg_target;
            err_nxt   = 1'b0;
            state_nxt = ST_READY;
          end else begin
            pat_nxt   = '0;
            len_nxt   = '0;
            tgt_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (state != ST_IDLE) begin
          if (abort) begin
            state_nxt = ST_READY;
          end else if (start) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            win_clr   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      tgt_q     <= '0;
      match_cnt <= '0;
      err       <= 1'b0;
      out       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pat_q     <= pat_nxt;
      len_q     <= len_nxt;
      tgt_q     <= tgt_nxt;
      match_cnt <= cnt_nxt;
      err       <= err_nxt;
      out       <= out_nxt;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: stimulus queues expected out pulses (cycle, count),
// a negedge monitor pops and compares them; status outputs are checked inline.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       seq_bit = 1'b0;
  logic       seq_valid = 1'b0;
  logic       out, busy, done, err;
  logic [7:0] match_cnt;

  seq_det_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .seq_bit     (seq_bit),
    .seq_valid   (seq_valid),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;
  exp_t sb[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every out pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && out) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_cnt", int'(match_cnt), e.cnt);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_target = t;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Drive one valid bit; if it completes a match, expect out one clock later.
  task automatic do_bit(input logic b, input bit m, input int c);
    exp_t e;
    seq_bit = b; seq_valid = 1'b1;
    if (m) begin
      e.cyc = cyc + 1;
      e.cnt = c;
      sb.push_back(e);
    end
    step();
    seq_valid = 1'b0;
  endtask

  task automatic status(string tag, int eb, int ed, int ee, int ec, int er);
    chk({tag, "_busy"}, int'(busy), eb);
    chk({tag, "_done"}, int'(done), ed);
    chk({tag, "_err"}, int'(err), ee);
    chk({tag, "_cnt"}, int'(match_cnt), ec);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] bits7;
    step(); step();
    chk("rst_out", int'(out), 0);
    status("rst", 0, 0, 0, 0, 1);
    resetn = 1'b1;
    step();

    // 0110, len 4, target 2: pulses after bits 4 and 7, then DONE
    do_cfg(8'h06, 4'd4, 8'd2);
    status("cfg1", 0, 0, 0, 0, 1);
    do_start();
    status("run1", 1, 0, 0, 0, 0);
    bits7 = 7'b0110110;
    for (int i = 6; i >= 0; i--) begin
      do_bit(bits7[i], (i == 3) || (i == 0), (i == 3) ? 1 : 2);
    end
    status("done1", 0, 1, 0, 2, 1);

    // Illegal lengths: err set, unconfigured, start ignored
    do_cfg(8'h00, 4'd1, 8'd0);
    status("len1", 0, 0, 1, 2, 1);
    do_start();
    chk("len1_start_busy", int'(busy), 0);
    do_cfg(8'hFF, 4'd9, 8'd0);
    chk("len9_err", int'(err), 1);
    do_start();
    chk("len9_start_busy", int'(busy), 0);

    // Unlimited mode, pattern 11: ten ones give nine overlapping matches
    do_cfg(8'h03, 4'd2, 8'd0);
    chk("cfg3_err_clr", int'(err), 0);
    do_start();
    for (int i = 0; i < 10; i++) begin
      do_bit(1'b1, i >= 1, i);
    end
    status("unl", 1, 0, 0, 9, 0);
    do_abort();
    status("unl_abort", 0, 0, 0, 9, 1);

    // Abort on the cycle the second match completes
    do_cfg(8'h06, 4'd4, 8'd3);
    do_start();
    bits7 = 7'b0110110;
    for (int i = 6; i >= 1; i--) begin
      do_bit(bits7[i], i == 3, 1);
    end
    seq_bit = 1'b0; seq_valid = 1'b1; abort = 1'b1;
    step();
    seq_valid = 1'b0; abort = 1'b0;
    step();
    status("abm", 0, 0, 0, 1, 1);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start_busy", int'(busy), 0);
    do_start();
    chk("ready_start_busy", int'(busy), 1);
    do_abort();

    // Reset mid-run after one match
    do_cfg(8'h03, 4'd2, 8'd0);
    do_start();
    do_bit(1'b1, 0, 0);
    do_bit(1'b1, 1, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_out", int'(out), 0);
    status("arst", 0, 0, 0, 0, 1);
    step();
    resetn = 1'b1;
    step();
    do_start();
    chk("post_rst_start_busy", int'(busy), 0);
    do_cfg(8'h03, 4'd2, 8'd0);
    do_start();
    chk("reload_start_busy", int'(busy), 1);
    do_abort();

    // Gaps of three idle cycles between pattern bits
    do_cfg(8'h06, 4'd4, 8'd0);
    do_start();
    do_bit(1'b0, 0, 0); repeat (3) step();
    do_bit(1'b1, 0, 0); repeat (3) step();
    do_bit(1'b1, 0, 0); repeat (3) step();
    do_bit(1'b0, 1, 1);
    repeat (3) step();
    status("gap", 1, 0, 0, 1, 0);
    do_abort();

    step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
